// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU result transmitter.
// Holds the transmitter FSM state type, entry/frame widths and the entry packing helper.
package alsu_pkg;

  localparam int unsigned RES_W      = 6;
  localparam int unsigned LEDS_W     = 16;
  localparam int unsigned ENTRY_W    = 7;
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Entry layout: error flag in the MSB above the raw result bits.
  function automatic logic [ENTRY_W-1:0] make_entry(input logic [RES_W-1:0]  res,
                                                    input logic [LEDS_W-1:0] leds);
    return {|leds, res};
  endfunction

endpackage

// File: rtl/alsu_res_fifo.sv
// Synchronous result FIFO.
// Ports:
//   clk, rst  - clock and asynchronous active-low reset
//   push, din - write request and data; accepted when not full, or when full with a pop
//   pop, dout - read request and head-of-queue data (dout valid while not empty)
//   full      - registered, FIFO holds Depth entries
//   empty     - registered, FIFO holds 0 entries
module alsu_res_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty_q;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full_q || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == DepthCnt);
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

  assign dout  = mem_q[rptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/alsu_result_tx.sv
// ALSU result transmitter: captures {err, result} entries into a FIFO and sends each one
// as a 10-bit UART-style frame (start, 7 data LSB first, even parity, stop).
// Ports:
//   clk, rst   - clock and asynchronous active-low reset
//   capture    - sample res_in/leds_in at this edge (level-sampled)
//   res_in     - ALSU result bit pattern
//   leds_in    - ALSU error LEDs; any set bit marks the entry as an error
//   tx         - registered serial line, idle high
//   busy       - registered, a frame is in flight
//   fifo_full  - registered FIFO full flag
//   fifo_empty - registered FIFO empty flag
//   overflow   - sticky, a capture was dropped
module alsu_result_tx
  import alsu_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic [RES_W-1:0]  res_in,
  input  logic [LEDS_W-1:0] leds_in,
  output logic              tx,
  output logic              busy,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              overflow
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CycLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      BitLast = 3'(ENTRY_W - 1);

  tx_state_t          state_q;
  logic [CntW-1:0]    cyc_q;
  logic [2:0]         bit_q;
  logic [ENTRY_W-1:0] shreg_q;
  logic               parity_q;
  logic               tx_q;
  logic               busy_q;
  logic               overflow_q;

  logic [ENTRY_W-1:0] fifo_dout;
  logic               fifo_full_w, fifo_empty_w;
  logic               pop;
  logic               bit_end;

  assign pop     = (state_q == IDLE) && !fifo_empty_w;
  assign bit_end = (cyc_q == CycLast);

  alsu_res_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .pop   (pop),
    .din   (make_entry(res_in, leds_in)),
    .dout  (fifo_dout),
    .full  (fifo_full_w),
    .empty (fifo_empty_w)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_q  <= START;
            shreg_q  <= fifo_dout;
            parity_q <= ^fifo_dout;
            cyc_q    <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            cyc_q   <= '0;
            tx_q    <= shreg_q[0];
          end else begin
            cyc_q <= cyc_q + CntW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc_q <= '0;
            if (bit_q == BitLast) begin
              state_q <= PARITY;
              tx_q    <= parity_q;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shreg_q <= shreg_q >> 1;
              // Next bit is what becomes the LSB after this shift.
              tx_q    <= shreg_q[1];
            end
          end else begin
            cyc_q <= cyc_q + CntW'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            cyc_q   <= '0;
            tx_q    <= 1'b1;
          end else begin
            cyc_q <= cyc_q + CntW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cyc_q <= cyc_q + CntW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A full FIFO only drops the capture when no pop frees a slot on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (capture && fifo_full_w && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_full  = fifo_full_w;
  assign fifo_empty = fifo_empty_w;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_alsu_result_tx.sv
module tb_alsu_result_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        capture = 1'b0;
  logic [5:0]  res_in = '0;
  logic [15:0] leds_in = '0;
  logic        tx, busy, fifo_full, fifo_empty, overflow;

  int checks = 0;
  int errors = 0;

  // Expected tx level after each successive clock edge.
  logic exp_q[$];

  alsu_result_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .res_in     (res_in),
    .leds_in    (leds_in),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame bits in transmission order: f[0] first.
  function automatic logic [9:0] frame_of(input logic [5:0] res, input logic [15:0] leds);
    logic [6:0] e;
    e = {(leds != 16'h0), res};
    return {1'b1, ^e, e, 1'b0};
  endfunction

  // One frame on the line followed by the single idle cycle between frames.
  task automatic model_frame(input logic [9:0] f);
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < CPB; c++) exp_q.push_back(f[b]);
    exp_q.push_back(1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if ({tx, busy, fifo_full, fifo_empty, overflow} !== 5'b10010) begin
      errors++;
      $display("FAIL reset_hold: got tx/busy/full/empty/ovf=%b required 10010",
               {tx, busy, fifo_full, fifo_empty, overflow});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({tx, busy, fifo_full, fifo_empty, overflow} !== 5'b10010) begin
      errors++;
      $display("FAIL reset_release: got tx/busy/full/empty/ovf=%b required 10010",
               {tx, busy, fifo_full, fifo_empty, overflow});
    end
  endtask

  task automatic run_one(input string name, input logic [5:0] r, input logic [15:0] l);
    logic [9:0] f;
    f = frame_of(r, l);
    exp_q.delete();
    model_frame(f);
    capture = 1'b1; res_in = r; leds_in = l;
    tick();  // capture edge k
    capture = 1'b0;
    checks++;
    if (fifo_empty !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_capture: got empty=%b tx=%b busy=%b required 0 1 0",
               name, fifo_empty, tx, busy);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      checks++;
      if (tx !== exp_q[i] || busy !== (i < 40)) begin
        errors++;
        $display("FAIL %s_cycle%0d: got tx=%b busy=%b required tx=%b busy=%b",
                 name, i, tx, busy, exp_q[i], (i < 40));
      end
    end
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL %s_drained: got empty=%b required 1", name, fifo_empty);
    end
  endtask

  task automatic test_single();
    run_one("single", 6'b101101, 16'h0000);
  endtask

  task automatic test_error_flag();
    run_one("errflag", 6'b000000, 16'hFFFF);
    run_one("randframe", 6'($urandom), 16'($urandom_range(0, 3)));
  endtask

  task automatic test_burst();
    logic [5:0]  r[4];
    logic [15:0] l[4];
    exp_q.delete();
    for (int j = 0; j < 4; j++) begin
      r[j] = 6'(j + 1);
      l[j] = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'h0;
      model_frame(frame_of(r[j], l[j]));
    end
    capture = 1'b1; res_in = r[0]; leds_in = l[0];
    tick();
    for (int i = 0; i < exp_q.size(); i++) begin
      capture = (i < 3);
      if (i < 3) begin
        res_in = r[i+1]; leds_in = l[i+1];
      end
      tick();
      checks++;
      if (tx !== exp_q[i] || fifo_full !== 1'b0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL burst_cycle%0d: got tx=%b full=%b ovf=%b required tx=%b full=0 ovf=0",
                 i, tx, fifo_full, overflow, exp_q[i]);
      end
    end
  endtask

  task automatic test_push_at_pop();
    logic [5:0]  r[6];
    logic [15:0] l[6];
    for (int j = 0; j < 6; j++) begin
      r[j] = 6'($urandom);
      l[j] = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'h0;
    end
    for (int j = 0; j < 5; j++) begin
      capture = 1'b1; res_in = r[j]; leds_in = l[j];
      tick();  // edges k .. k+4
    end
    capture = 1'b0;
    checks++;
    if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL pap_filled: got full=%b ovf=%b required 1 0", fifo_full, overflow);
    end
    repeat (37) tick();  // now after edge k+41: first frame done, FSM idle
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL pap_idle_gap: got tx=%b busy=%b full=%b required 1 0 1",
               tx, busy, fifo_full);
    end
    capture = 1'b1; res_in = r[5]; leds_in = l[5];
    tick();  // pop and push together
    capture = 1'b0;
    checks++;
    if (fifo_full !== 1'b1 || overflow !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pap_same_edge: got full=%b ovf=%b busy=%b required 1 0 1",
               fifo_full, overflow, busy);
    end
    exp_q.delete();
    for (int j = 1; j < 6; j++) model_frame(frame_of(r[j], l[j]));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      checks++;
      if (tx !== exp_q[i] || overflow !== 1'b0) begin
        errors++;
        $display("FAIL pap_cycle%0d: got tx=%b ovf=%b required tx=%b ovf=0",
                 i, tx, overflow, exp_q[i]);
      end
    end
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL pap_drained: got empty=%b required 1", fifo_empty);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] l[6];
    exp_q.delete();
    for (int j = 0; j < 6; j++) begin
      l[j] = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'h0;
      if (j < 5) model_frame(frame_of(6'(10 + j), l[j]));
    end
    capture = 1'b1; res_in = 6'd10; leds_in = l[0];
    tick();  // edge k
    for (int i = 0; i < exp_q.size(); i++) begin
      capture = (i < 5);
      if (i < 5) begin
        res_in = 6'(11 + i); leds_in = l[i+1];
      end
      tick();  // edge k+1+i
      checks++;
      if (tx !== exp_q[i] || overflow !== (i >= 4)) begin
        errors++;
        $display("FAIL ovf_cycle%0d: got tx=%b ovf=%b required tx=%b ovf=%b",
                 i, tx, overflow, exp_q[i], (i >= 4));
      end
      if (i == 3) begin
        checks++;
        if (fifo_full !== 1'b1) begin
          errors++;
          $display("FAIL ovf_full: got full=%b required 1", fifo_full);
        end
      end
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_empty !== 1'b1 || overflow !== 1'b1) begin
        errors++;
        $display("FAIL ovf_tail%0d: got tx=%b busy=%b empty=%b ovf=%b required 1 0 1 1",
                 i, tx, busy, fifo_empty, overflow);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int j = 0; j < 3; j++) begin
      capture = 1'b1; res_in = 6'($urandom); leds_in = 16'($urandom);
      tick();
    end
    capture = 1'b0;
    repeat (8) tick();  // well inside the data bits
    checks++;
    if (busy !== 1'b1 || fifo_empty !== 1'b0) begin
      errors++;
      $display("FAIL midrst_setup: got busy=%b empty=%b required 1 0", busy, fifo_empty);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({tx, busy, fifo_full, fifo_empty, overflow} !== 5'b10010) begin
      errors++;
      $display("FAIL midrst_async: got tx/busy/full/empty/ovf=%b required 10010",
               {tx, busy, fifo_full, fifo_empty, overflow});
    end
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_empty !== 1'b1) begin
        errors++;
        $display("FAIL midrst_after%0d: got tx=%b busy=%b empty=%b required 1 0 1",
                 i, tx, busy, fifo_empty);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_error_flag();
    test_burst();
    test_push_at_pop();
    test_overflow();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alsu_result_tx.md
# alsu_result_tx

Downstream stage of the ALSU. On a capture strobe it samples the ALSU registered result (`out`) and error indication (`leds`) into a small FIFO. It then serializes each entry as a UART-style frame on a single `tx` line, so results can be read off-chip or by a monitor while the ALSU keeps running.

## Interface
Parameters:
- `CLKS_PER_BIT`, 4: clock cycles per serial bit; legal range ≥2.
- `FIFO_DEPTH`, 4: result FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low (asserted at 0).
- `capture`  in  1  sample `res_in`/`leds_in` at this rising edge.
- `res_in`  in  6  ALSU `out`, signed, transported as a raw bit pattern.
- `leds_in`  in  16  ALSU `leds`.
- `tx`  out  1  serial line; idle high; registered.
- `busy`  out  1  high while a frame is in flight (state ≠ IDLE).
- `fifo_full`  out  1  FIFO holds FIFO_DEPTH entries.
- `fifo_empty`  out  1  FIFO holds 0 entries.
- `overflow`  out  1  sticky; a capture was dropped.

## Operation
- Entry is 7 bits: `{err, res_in[5:0]}`, where `err = |leds_in`. `err` is the MSB.
- Frame is 10 bits, sent in this order:
  - start bit = 0;
  - 7 data bits, LSB first (`res_in[0]` first, `err` last);
  - even-parity bit = ^entry;
  - stop bit = 1.
- FSM states and transitions:
  - IDLE → START when the FIFO is non-empty. On that edge, pop the head into the shift register and clear the bit/cycle counters.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → PARITY after 7 × CLKS_PER_BIT cycles. The shift register shifts right at each bit boundary.
  - PARITY → STOP after CLKS_PER_BIT cycles.
  - STOP → IDLE after CLKS_PER_BIT cycles.
- `tx` is driven from a register that is updated on the same edge as each state/bit change:
  - IDLE = 1, START = 0, DATA = current LSB, PARITY = parity, STOP = 1.
- Push:
  - `capture` high and FIFO not full → write the entry.
  - `capture` high and FIFO full, with no pop on the same edge → entry discarded, `overflow` set. `overflow` clears only on reset.
- Simultaneous push and pop on the same edge:
  - Always legal, including when full; occupancy is unchanged.
  - On an empty FIFO a pop cannot occur, so the push simply writes.
- Capture is level-sampled every edge: holding `capture` high for N cycles pushes N entries.

## Timing
- All outputs are reset to: `tx` = 1, `busy` = 0, `fifo_full` = 0, `fifo_empty` = 1, `overflow` = 0. The FSM resets to IDLE and the FIFO pointers to 0.
- Reset mid-frame aborts the frame immediately (asynchronously): `tx` returns high and FIFO contents are lost.
- Latency: with `capture` at edge k into an empty FIFO and an IDLE FSM:
  - `fifo_empty` falls after edge k;
  - the pop and START happen at edge k+1, so `tx` falls after edge k+1;
  - STOP ends at edge k+1+10·CLKS_PER_BIT.
- At least one IDLE cycle (`tx` = 1) separates back-to-back frames. The frame period is 10·CLKS_PER_BIT+1 cycles.
- `fifo_full`, `fifo_empty` and `overflow` are registered and reflect occupancy after the current edge.
- FIFO occupancy counter width is clog2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.

## Structure
- Shared package `alsu_pkg` holds:
  - the FSM state enum `tx_state_t` {IDLE, START, DATA, PARITY, STOP};
  - `RES_W` = 6, `ENTRY_W` = 7, `FRAME_BITS` = 10.
- Sub-module `alsu_res_fifo`: synchronous FIFO, with ports `push`, `pop`, `din`, `dout`, `full`, `empty`, same clock and reset. The top level holds the FSM, counters, shift register, parity and `overflow`.

## Test plan
All scenarios use CLKS_PER_BIT = 4 and FIFO_DEPTH = 4.
- **Single frame:** `res_in` = 6'b101101, `leds_in` = 0, one capture.
  - Required: `tx` sequence 0,1,0,1,1,0,1,0,0,1, each bit held 4 cycles. The start bit begins 1 cycle after the capture edge. `busy` is high for 40 cycles.
- **Error flag:** `res_in` = 0, `leds_in` = 16'hFFFF.
  - Required: data bits 0,0,0,0,0,0,1, parity 1.
- **Burst of 4:** captures of 1, 2, 3, 4 on 4 consecutive cycles.
  - Required: `fifo_full` is never asserted (the first entry pops at edge k+1). Four frames come out in order, each separated by exactly 1 idle cycle. `overflow` stays 0.
- **Overflow:** 6 consecutive captures of 10..15.
  - Required: entries 10, 11, 12, 13, 14 are transmitted; 15 is dropped. `overflow` = 1 after the 6th edge and holds until reset.
- **Reset mid-frame:** assert `rst` = 0 during DATA of the first frame, with 2 entries queued.
  - Required: `tx` = 1 and `busy` = 0 immediately. After release, no frame is sent and `fifo_empty` = 1.
- **Push at pop:** FIFO full, with `capture` coinciding with the IDLE→START edge.
  - Required: the new entry is accepted, `overflow` stays 0, and occupancy stays 4.
